// File: rtl/main_mem_burst.sv
// rtl/main_mem_burst.sv - line-granular main-memory model with programmable latency
//
// Serves one line-fill read or dirty-line write-back at a time for the data
// cache. A request is latched in IDLE, waits READ_LATENCY cycles, moves one
// 32-bit word per cycle, then pulses gnt for one cycle.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   mem_addr  line address of the request
//   rd_req    line-fill request, held until gnt
//   wr_req    write-back request, held until gnt (wins over rd_req)
//   wr_line   line to write, word k at [32k+31:32k]
//   rd_line   line returned by the last completed read
//   gnt       one-cycle completion pulse
//   busy      high whenever a transaction is in progress
//   rd_cnt    completed read transactions
//   wr_cnt    completed write transactions
module main_mem_burst #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 8,
  parameter int READ_LATENCY  = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MEM_ADDR_LEN-1:0]           mem_addr,
  input  logic                              rd_req,
  input  logic                              wr_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]  wr_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]  rd_line,
  output logic                              gnt,
  output logic                              busy,
  output logic [31:0]                       rd_cnt,
  output logic [31:0]                       wr_cnt
);

  localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN;
  localparam int LINE_BITS     = 32 * LINE_SIZE;
  localparam int WORD_ADDR_LEN = MEM_ADDR_LEN + LINE_ADDR_LEN;
  localparam int DEPTH         = 1 << WORD_ADDR_LEN;
  localparam logic [31:0] WAIT_LOAD = (READ_LATENCY > 0) ? 32'(READ_LATENCY - 1) : 32'd0;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t                     state;
  logic [31:0]                mem [DEPTH];
  logic [MEM_ADDR_LEN-1:0]    addr_q;
  logic                       op_wr;
  logic [LINE_ADDR_LEN-1:0]   word_idx;
  logic [LINE_BITS-1:0]       wr_line_q;
  logic [31:0]                wait_cnt;
  logic [WORD_ADDR_LEN-1:0]   word_addr;
  logic [LINE_ADDR_LEN+4:0]   bit_base;

  // Word index sits in the low bits, so k never carries into the line address.
  assign word_addr = {addr_q, word_idx};
  assign bit_base  = {word_idx, 5'b0};

  // Storage powers up holding its own word index; reset leaves it alone.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[WORD_ADDR_LEN'(i)] = 32'(i);
  end

  // Not gated by rst: a write word on the reset edge still lands, matching
  // the rule that an aborted write-back keeps what it already stored.
  always_ff @(posedge clk) begin
    if (state == XFER && op_wr)
      mem[word_addr] <= wr_line_q[bit_base +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      rd_line   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      addr_q    <= '0;
      op_wr     <= 1'b0;
      word_idx  <= '0;
      wr_line_q <= '0;
      wait_cnt  <= '0;
    end else begin
      gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            addr_q   <= mem_addr;
            op_wr    <= wr_req;
            word_idx <= '0;
            busy     <= 1'b1;
            if (wr_req) wr_line_q <= wr_line;
            if (READ_LATENCY == 0) begin
              state <= XFER;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 32'd0) begin
            state    <= XFER;
            word_idx <= '0;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        XFER: begin
          if (!op_wr) rd_line[bit_base +: 32] <= mem[word_addr];
          word_idx <= word_idx + 1'b1;
          // Counters step together with gnt so they are current while gnt is seen.
          if (word_idx == LAST_IDX) begin
            state <= DONE;
            gnt   <= 1'b1;
            if (op_wr) wr_cnt <= wr_cnt + 32'd1;
            else       rd_cnt <= rd_cnt + 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_burst.sv
// tb/tb_main_mem_burst.sv - self-checking bench for main_mem_burst
module tb_main_mem_burst;

  localparam int RL = 50;
  localparam int LS = 8;

  logic         clk, rst;
  logic [7:0]   mem_addr;
  logic         rd_req, wr_req;
  logic [255:0] wr_line, rd_line;
  logic         gnt, busy;
  logic [31:0]  rd_cnt, wr_cnt;

  logic [7:0]   mem_addr1;
  logic         rd_req1, wr_req1;
  logic [255:0] wr_line1, rd_line1;
  logic         gnt1, busy1;
  logic [31:0]  rd_cnt1, wr_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Spec-level model: acceptance time, latched request and memory image.
  logic [31:0]  model_mem [2048];
  bit           m_active;
  bit           m_op_wr;
  int           m_t;
  logic [7:0]   m_addr;
  logic [255:0] m_line;
  logic [255:0] m_rd_line;
  logic [31:0]  m_rd_cnt, m_wr_cnt;

  main_mem_burst #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .busy(busy),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

  main_mem_burst #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(8), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr1), .rd_req(rd_req1), .wr_req(wr_req1),
    .wr_line(wr_line1), .rd_line(rd_line1), .gnt(gnt1), .busy(busy1),
    .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < LS; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  // Model update at every active edge.
  initial begin
    for (int i = 0; i < 2048; i++) model_mem[i] = 32'(i);
    m_active = 0; m_op_wr = 0; m_t = 0; m_addr = 0; m_line = '0;
    m_rd_line = '0; m_rd_cnt = 0; m_wr_cnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (m_active && m_op_wr) begin
        int k;
        k = cyc - (m_t + RL + 1);
        if (k >= 0 && k < LS) model_mem[int'(m_addr) * LS + k] = m_line[k*32 +: 32];
      end
      if (rst) begin
        m_active = 0; m_rd_line = '0; m_rd_cnt = 0; m_wr_cnt = 0;
      end else if (m_active) begin
        if (cyc == m_t + RL + LS) begin
          if (m_op_wr) m_wr_cnt = m_wr_cnt + 1;
          else begin
            for (int k = 0; k < LS; k++) m_rd_line[k*32 +: 32] = model_mem[int'(m_addr) * LS + k];
            m_rd_cnt = m_rd_cnt + 1;
          end
        end
        if (cyc == m_t + RL + LS + 1) m_active = 0;
      end else if (rd_req || wr_req) begin
        m_active = 1; m_t = cyc; m_op_wr = wr_req; m_addr = mem_addr;
        if (wr_req) m_line = wr_line;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        bit exp_gnt;
        exp_gnt = m_active && (cyc == m_t + RL + LS);
        chk("cyc_gnt", gnt, exp_gnt);
        chk("cyc_busy", busy, m_active);
        chk("cyc_rd_cnt", rd_cnt, m_rd_cnt);
        chk("cyc_wr_cnt", wr_cnt, m_wr_cnt);
        if (!m_active || m_op_wr || exp_gnt) chk("cyc_rd_line", rd_line, m_rd_line);
      end
    end
  end

  task automatic wait_gnt(input string nm, output int tg);
    tg = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (gnt) begin
        tg = cyc;
        break;
      end
    end
    if (tg < 0) begin
      checks++; errors++;
      $display("FAIL %s: gnt timeout got none expected pulse", nm);
    end
  endtask

  task automatic xact(input string nm, input bit wr, input logic [7:0] a,
                      input logic [255:0] line);
    int t_acc, tg;
    mem_addr = a; wr_line = line;
    if (wr) wr_req = 1'b1; else rd_req = 1'b1;
    t_acc = cyc + 1;
    wait_gnt(nm, tg);
    rd_req = 1'b0; wr_req = 1'b0;
    chk({nm, "_lat"}, 256'(tg - t_acc), 256'(RL + LS));
  endtask

  initial begin
    int t_acc, tg, tg2;
    logic [255:0] exp_l;
    rst = 1'b1; rd_req = 0; wr_req = 0; mem_addr = 0; wr_line = '0;
    rd_req1 = 0; wr_req1 = 0; mem_addr1 = 0; wr_line1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_rd_line", rd_line, 0);
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_wr_cnt", wr_cnt, 0);

    // Plain read of line 5.
    mem_addr = 8'h05; rd_req = 1'b1; t_acc = cyc + 1;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    wait_gnt("t1", tg);
    rd_req = 1'b0;
    chk("t1_lat", 256'(tg - t_acc), 256'(58));
    chk("t1_line", rd_line, seq_line(32'd40));
    chk("t1_rd_cnt", rd_cnt, 1);
    chk("t1_wr_cnt", wr_cnt, 0);
    @(negedge clk);

    // Write-back then read back, neighbour line untouched.
    xact("t2w", 1'b1, 8'h05, seq_line(32'hA0));
    @(negedge clk);
    chk("t2_rd_line_hold", rd_line, seq_line(32'd40));
    xact("t2r", 1'b0, 8'h05, '0);
    chk("t2_line", rd_line, seq_line(32'hA0));
    chk("t2_wr_cnt", wr_cnt, 1);
    chk("t2_rd_cnt", rd_cnt, 2);
    @(negedge clk);
    xact("t2n", 1'b0, 8'h06, '0);
    chk("t2_adj_line", rd_line, seq_line(32'd48));
    @(negedge clk);

    // Simultaneous requests: write first, read follows after one idle cycle.
    mem_addr = 8'h02; wr_line = seq_line(32'hB0); rd_req = 1'b1; wr_req = 1'b1;
    t_acc = cyc + 1;
    wait_gnt("t3w", tg);
    wr_req = 1'b0;
    chk("t3w_lat", 256'(tg - t_acc), 256'(58));
    chk("t3_wr_cnt", wr_cnt, 2);
    chk("t3_rd_cnt_mid", rd_cnt, 3);
    wait_gnt("t3r", tg2);
    rd_req = 1'b0;
    chk("t3r_gap", 256'(tg2 - tg), 256'(60));
    chk("t3_line", rd_line, seq_line(32'hB0));
    chk("t3_rd_cnt", rd_cnt, 4);
    @(negedge clk);

    // Inputs wiggled during WAIT must not affect the transaction.
    mem_addr = 8'h07; rd_req = 1'b1; t_acc = cyc + 1;
    repeat (10) @(negedge clk);
    mem_addr = 8'h01; wr_req = 1'b1; wr_line = seq_line(32'h5555_0000);
    @(negedge clk);
    wr_req = 1'b0;
    wait_gnt("t4", tg);
    rd_req = 1'b0;
    chk("t4_lat", 256'(tg - t_acc), 256'(58));
    chk("t4_line", rd_line, seq_line(32'd56));
    chk("t4_rd_cnt", rd_cnt, 5);
    chk("t4_wr_cnt", wr_cnt, 2);
    @(negedge clk);

    // Reset while writing word 3 of line 3.
    mem_addr = 8'h03; wr_line = seq_line(32'hDEAD_0000); wr_req = 1'b1;
    repeat (54) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt, 0);
    chk("t5_rd_cnt", rd_cnt, 0);
    chk("t5_wr_cnt", wr_cnt, 0);
    @(negedge clk);
    xact("t5r", 1'b0, 8'h03, '0);
    exp_l = seq_line(32'd24);
    for (int k = 0; k < 4; k++) exp_l[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    chk("t5_line", rd_line, exp_l);
    chk("t5_rd_cnt2", rd_cnt, 1);
    chk("t5_wr_cnt2", wr_cnt, 0);

    // Zero-latency instance, last line.
    @(negedge clk);
    mem_addr1 = 8'hFF; rd_req1 = 1'b1; t_acc = cyc + 1; tg = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (gnt1) begin
        tg = cyc;
        break;
      end
    end
    rd_req1 = 1'b0;
    chk("t6_lat", 256'(tg - t_acc), 256'(8));
    chk("t6_line", rd_line1, seq_line(32'd2040));
    chk("t6_rd_cnt", rd_cnt1, 1);
    chk("t6_wr_cnt", wr_cnt1, 0);
    @(negedge clk);
    chk("t6_gnt_low", gnt1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
